// File: rtl/riscv_fetch_pkg.sv
// ============================================================================
// Module   : riscv_fetch_pkg
// Purpose  : Shared constants and the fetch-buffer entry type for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_fetch_pkg;

  localparam int INSTR_WIDTH  = 32;
  localparam int PC_STEP      = 4;
  // The entry type is fixed-width, so the PC field is sized for the widest
  // address any instance may use and each instance uses only its low bits.
  localparam int PC_WIDTH_MAX = 32;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]  inst;
    logic [PC_WIDTH_MAX-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of fetch entries with push, pop and flush.
//            Flush has priority over push.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC register, instruction buffer and
//            valid/ready hand-off to decode. Optional misaligned-redirect trap
//            enabled by defining FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INSTR_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]    inst_pc,
  output logic                   misalign_err
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_redirect_pc;
  logic                w_halted;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  fetch_entry_t        w_wentry;
  fetch_entry_t        w_head;

  assign imem_addr = r_pc;

  assign w_pop  = inst_valid & inst_ready;
  assign w_push = fetch_en & ~redirect_valid & (~w_full | w_pop) & ~w_halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halted;
  logic r_misalign_err;

  // Misaligned redirect parks fetch at the bad target until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted       <= 1'b0;
      r_misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      r_halted       <= 1'b1;
      r_misalign_err <= 1'b1;
    end
  end

  assign w_halted      = r_halted;
  assign misalign_err  = r_misalign_err;
  assign w_redirect_pc = redirect_target;
`else
  logic [1:0] w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = redirect_target[1:0];
  assign w_halted         = 1'b0;
  assign misalign_err     = 1'b0;
  assign w_redirect_pc    = {redirect_target[PC_WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid && !w_halted) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + PC_WIDTH'(PC_STEP);
    end
  end

  always_comb begin
    w_wentry                   = '0;
    w_wentry.inst              = imem_data;
    w_wentry.pc[PC_WIDTH-1:0]  = r_pc;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  generate
    if (PC_WIDTH < PC_WIDTH_MAX) begin : g_pc_hi
      logic [PC_WIDTH_MAX-PC_WIDTH-1:0] w_unused_pc_hi;
      assign w_unused_pc_hi = w_head.pc[PC_WIDTH_MAX-1:PC_WIDTH];
    end
  endgenerate

  // Head fields are masked so decode sees zeros whenever nothing is valid.
  assign inst_valid = ~w_empty;
  assign inst       = w_empty ? '0 : w_head.inst;
  assign inst_pc    = w_empty ? '0 : w_head.pc[PC_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking scoreboard bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [9:0]  inst_pc;
  logic        misalign_err;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {a, 6'h2A, 6'h15, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_unit #(
    .PC_WIDTH   (10),
    .RESET_PC   (10'd0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign_err    (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [9:0] start, input int n);
    logic [9:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{pc: p, inst: mem_word(p)});
      p = p + 10'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle redirect pulse; the scoreboard restarts at the landing address.
  task automatic redirect(input logic [9:0] tgt);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc", 32'(inst_pc), 32'(e.pc));
        chk("sb_inst", inst, e.inst);
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #12;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    tick();
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("idle_addr", 32'(imem_addr), 32'd0);
    chk("idle_valid", 32'(inst_valid), 32'd0);

    // Back-pressure from reset: buffer fills with PC 0 and 4, PC stalls at 8.
    tick();
    fetch_en = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("bp_addr", 32'(imem_addr), 32'd8);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_pc", 32'(inst_pc), 32'd0);
    chk("bp_inst", inst, mem_word(10'd0));
    push_seq(10'd0, 40);
    tick();
    inst_ready = 1'b1;
    repeat (8) tick();

    // Redirect while the buffer is full of stale entries.
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect(10'h100);
    push_seq(10'h100, 40);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("rd_n1_valid", 32'(inst_valid), 32'd0);
    chk("rd_n1_addr", 32'(imem_addr), 32'h100);
    @(negedge clk);
    chk("rd_n2_valid", 32'(inst_valid), 32'd1);
    chk("rd_n2_pc", 32'(inst_pc), 32'h100);
    @(negedge clk);
    chk("steady_gap", 32'(imem_addr), 32'(inst_pc + 10'd4));

    // fetch_en low: buffer drains, PC holds.
    tick();
    fetch_en = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("hold_addr", 32'(imem_addr), 32'h10C);
    chk("hold_valid", 32'(inst_valid), 32'd0);
    tick();
    fetch_en = 1'b1;
    repeat (4) tick();

    // Back-to-back redirects, last one wins; then wrap past 1020.
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 10'h200;
    tick();
    redirect_target = 10'h3F8;
    tick();
    redirect_valid  = 1'b0;
    sb_q.delete();
    push_seq(10'h3F8, 20);
    @(negedge clk);
    chk("b2b_addr", 32'(imem_addr), 32'h3F8);
    chk("b2b_valid", 32'(inst_valid), 32'd0);
    repeat (7) tick();

    redirect(10'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_addr", 32'(imem_addr), 32'h102);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    repeat (4) tick();
    @(negedge clk);
    chk("mis_err_hold", 32'(misalign_err), 32'd1);
    chk("mis_addr_hold", 32'(imem_addr), 32'h102);
    chk("mis_valid_hold", 32'(inst_valid), 32'd0);
    tick();
    rst_n = 1'b0;
    #2;
    chk("mis_rst_err", 32'(misalign_err), 32'd0);
    chk("mis_rst_addr", 32'(imem_addr), 32'd0);
    sb_q.delete();
    push_seq(10'd0, 20);
    tick();
    rst_n = 1'b1;
`else
    push_seq(10'h100, 20);
    @(negedge clk);
    chk("mis_err", 32'(misalign_err), 32'd0);
    chk("mis_addr", 32'(imem_addr), 32'h100);
`endif
    repeat (4) tick();

    // Asynchronous reset mid-stream, checked before the next clock edge.
    redirect(10'h040);
    push_seq(10'h040, 20);
    repeat (3) tick();
    #2;
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_pc", 32'(inst_pc), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    sb_q.delete();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
